// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator: parallel per-channel integrators, one time-shared comb
// engine, and a serialized channel output stream with valid/ready backpressure.
module cic_decimator_mc #(
  parameter int N_CH          = 4,
  parameter int INPUT_WIDTH   = 24,
  parameter int OUTPUT_WIDTH  = 16,
  parameter int M_STAGES      = 3,
  parameter int R_MAX         = 256,
  parameter int R_DEFAULT     = 192,
  parameter int SHIFT_DEFAULT = 23
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic [N_CH*INPUT_WIDTH-1:0]                             x_in,
  input  logic                                                    x_valid,
  input  logic                                                    cfg_load,
  input  logic [$clog2(R_MAX):0]                                  cfg_r,
  input  logic [$clog2(INPUT_WIDTH+M_STAGES*$clog2(R_MAX))-1:0]   cfg_shift,
  output logic signed [OUTPUT_WIDTH-1:0]                          y_out,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]              y_ch,
  output logic                                                    y_valid,
  output logic                                                    y_last,
  input  logic                                                    y_ready,
  output logic                                                    overrun,
  output logic                                                    cfg_err
);

  localparam int W    = INPUT_WIDTH + M_STAGES*$clog2(R_MAX);
  localparam int RW   = $clog2(R_MAX) + 1;
  localparam int SW   = $clog2(W);
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DROP = INPUT_WIDTH - OUTPUT_WIDTH;
  localparam int OW   = OUTPUT_WIDTH;

  logic signed [W-1:0] integ_q [N_CH][M_STAGES];
  logic signed [W-1:0] integ_d [N_CH][M_STAGES];
  logic signed [W-1:0] dly_q   [N_CH][M_STAGES];
  logic signed [W-1:0] dly_d   [N_CH][M_STAGES];
  logic signed [W-1:0] snap_q  [N_CH];
  logic signed [W-1:0] snap_d  [N_CH];

  logic [RW-1:0]        cnt_q, cnt_d, r_q, r_d;
  logic [SW-1:0]        shift_q, shift_d;
  logic                 event_q, event_d;
  logic                 pending_q, pending_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic signed [OW-1:0] y_out_q, y_out_d;
  logic [CW-1:0]        y_ch_q, y_ch_d;
  logic                 y_valid_q, y_valid_d;
  logic                 y_last_q, y_last_d;
  logic                 overrun_q, overrun_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 cfg_ok;
  logic                 fire;
  logic signed [W-1:0]  comb_tap [M_STAGES];
  logic signed [W-1:0]  scaled;
  logic signed [OW-1:0] y_sat;

  assign cfg_ok = cfg_load && (cfg_r >= RW'(2)) && (cfg_r <= RW'(R_MAX)) &&
                  (cfg_r >= RW'(N_CH + 3));
  assign fire   = pending_q && (!y_valid_q || y_ready);

  // Comb chain for the channel currently selected; taps become the new delays.
  always_comb begin
    logic signed [W-1:0] acc;
    acc = snap_q[ch_q];
    for (int k = 0; k < M_STAGES; k++) begin
      comb_tap[k] = acc;
      acc         = acc - dly_q[ch_q][k];
    end
    scaled = (acc >>> shift_q) >>> DROP;
    if ((scaled[W-1:OW-1] == '0) || (scaled[W-1:OW-1] == '1)) begin
      y_sat = scaled[OW-1:0];
    end else begin
      y_sat = scaled[W-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
  end

  always_comb begin
    integ_d   = integ_q;
    dly_d     = dly_q;
    snap_d    = snap_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    shift_d   = shift_q;
    event_d   = 1'b0;
    pending_d = pending_q;
    ch_d      = ch_q;
    y_out_d   = y_out_q;
    y_ch_d    = y_ch_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    overrun_d = overrun_q;
    cfg_err_d = 1'b0;

    if (cfg_ok) begin
      for (int c = 0; c < N_CH; c++) begin
        snap_d[c] = '0;
        for (int k = 0; k < M_STAGES; k++) begin
          integ_d[c][k] = '0;
          dly_d[c][k]   = '0;
        end
      end
      cnt_d     = '0;
      pending_d = 1'b0;
      ch_d      = '0;
      y_valid_d = 1'b0;
      overrun_d = 1'b0;
      r_d       = cfg_r;
      shift_d   = cfg_shift;
    end else begin
      cfg_err_d = cfg_load;

      if (x_valid) begin
        for (int c = 0; c < N_CH; c++) begin
          integ_d[c][0] = integ_q[c][0] +
            {{(W-INPUT_WIDTH){x_in[c*INPUT_WIDTH+INPUT_WIDTH-1]}},
             x_in[c*INPUT_WIDTH +: INPUT_WIDTH]};
          for (int k = 1; k < M_STAGES; k++) begin
            integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
          end
        end
        if (cnt_q == r_q - RW'(1)) begin
          cnt_d   = '0;
          event_d = 1'b1;
        end else begin
          cnt_d = cnt_q + RW'(1);
        end
      end

      // A frame arriving while the previous one is still in the comb engine is dropped.
      if (event_q) begin
        if (!pending_q) begin
          for (int c = 0; c < N_CH; c++) begin
            snap_d[c] = integ_q[c][M_STAGES-1];
          end
          pending_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end

      if (fire) begin
        for (int k = 0; k < M_STAGES; k++) begin
          dly_d[ch_q][k] = comb_tap[k];
        end
        y_out_d   = y_sat;
        y_ch_d    = ch_q;
        y_last_d  = (ch_q == CW'(N_CH - 1));
        y_valid_d = 1'b1;
        if (ch_q == CW'(N_CH - 1)) begin
          ch_d      = '0;
          pending_d = 1'b0;
        end else begin
          ch_d = ch_q + CW'(1);
        end
      end else if (y_valid_q && y_ready) begin
        y_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        snap_q[c] <= '0;
        for (int k = 0; k < M_STAGES; k++) begin
          integ_q[c][k] <= '0;
          dly_q[c][k]   <= '0;
        end
      end
      cnt_q     <= '0;
      r_q       <= RW'(R_DEFAULT);
      shift_q   <= SW'(SHIFT_DEFAULT);
      event_q   <= 1'b0;
      pending_q <= 1'b0;
      ch_q      <= '0;
      y_out_q   <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      overrun_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      integ_q   <= integ_d;
      dly_q     <= dly_d;
      snap_q    <= snap_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      shift_q   <= shift_d;
      event_q   <= event_d;
      pending_q <= pending_d;
      ch_q      <= ch_d;
      y_out_q   <= y_out_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
      overrun_q <= overrun_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;
  assign overrun = overrun_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Scoreboard bench for cic_decimator_mc: stimulus queues expected beats, a negedge
// monitor pops and compares every accepted beat (and the held beat while stalled).
module tb_cic_decimator_mc;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [95:0]        x_in;
  logic               x_valid;
  logic               cfg_load;
  logic [8:0]         cfg_r;
  logic [5:0]         cfg_shift;
  logic signed [15:0] y_out;
  logic [1:0]         y_ch;
  logic               y_valid;
  logic               y_last;
  logic               y_ready;
  logic               overrun;
  logic               cfg_err;

  cic_decimator_mc dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid),
    .cfg_load(cfg_load), .cfg_r(cfg_r), .cfg_shift(cfg_shift),
    .y_out(y_out), .y_ch(y_ch), .y_valid(y_valid), .y_last(y_last),
    .y_ready(y_ready), .overrun(overrun), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    bit chk;
    int ch;
    bit last;
    int cyc;
  } exp_t;

  exp_t q[$];
  int ncmp = 0;
  int nfail = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: accepted beats are popped; a stalled beat must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && y_valid) begin
      if (y_ready) begin
        if (q.size() == 0) begin
          cmp("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          cmp("beat_ch", int'(y_ch), e.ch);
          cmp("beat_last", int'(y_last), int'(e.last));
          if (e.chk) cmp("beat_value", int'(y_out), e.val);
          if (e.cyc >= 0) cmp("beat_cycle", cyc, e.cyc);
        end
      end else if (q.size() != 0) begin
        cmp("held_ch", int'(y_ch), q[0].ch);
        cmp("held_last", int'(y_last), int'(q[0].last));
        if (q[0].chk) cmp("held_value", int'(y_out), q[0].val);
      end
    end
  end

  task automatic set_x(input int v);
    for (int c = 0; c < 4; c++) x_in[c*24 +: 24] = v[23:0];
  endtask

  task automatic push_frame(input int t_first, input bit chk0, input int v0,
                            input bit chk_o, input int vo);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      e.val  = (c == 0) ? v0 : vo;
      e.chk  = (c == 0) ? chk0 : chk_o;
      e.ch   = c;
      e.last = (c == 3);
      e.cyc  = (t_first < 0) ? -1 : t_first + c;
      q.push_back(e);
    end
  endtask

  // Continuous x_valid for n*r samples starting now; frame f's ch0 is expected
  // at cycle t0 + f*r + 2. Frames before chk_from carry transient values.
  task automatic run(input int n, input int r, input int chk_from, input int v,
                     input bit sine);
    int t0;
    int xs;
    real ph;
    t0 = cyc;
    for (int f = 1; f <= n; f++) begin
      if (sine) push_frame(t0 + f*r + 2, 1'b0, 0, 1'b1, 0);
      else      push_frame(t0 + f*r + 2, f >= chk_from, v, f >= chk_from, v);
    end
    x_valid = 1'b1;
    for (int i = 0; i < n*r; i++) begin
      if (sine) begin
        ph = 2.0 * 3.14159265358979 * i / 3072.0;
        xs = $rtoi(4194304.0 * $sin(ph));
        x_in[23:0] = xs[23:0];
      end
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    cmp("queue_drained", q.size(), 0);
  endtask

  task automatic do_cfg(input int r, input int s, input bit with_valid);
    cfg_r     = r[8:0];
    cfg_shift = s[5:0];
    cfg_load  = 1'b1;
    x_valid   = with_valid;
    @(posedge clk); #1;
    cfg_load  = 1'b0;
  endtask

  task automatic cfg_reject(input int r);
    cfg_r     = r[8:0];
    cfg_shift = 6'd0;
    cfg_load  = 1'b1;
    @(posedge clk); #1;
    cfg_load  = 1'b0;
    cmp("cfg_err_pulse", int'(cfg_err), 1);
    @(posedge clk); #1;
    cmp("cfg_err_clear", int'(cfg_err), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    rst_n = 1'b0; x_in = '0; x_valid = 1'b0; cfg_load = 1'b0;
    cfg_r = '0; cfg_shift = '0; y_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    cmp("rst_y_out", int'(y_out), 0);
    cmp("rst_y_ch", int'(y_ch), 0);
    cmp("rst_y_valid", int'(y_valid), 0);
    cmp("rst_y_last", int'(y_last), 0);
    cmp("rst_overrun", int'(overrun), 0);
    cmp("rst_cfg_err", int'(cfg_err), 0);

    // DC at defaults: steady 2^20 * 192^3 >> 23 >> 8 = 3456 from frame 3
    set_x(1 << 20);
    rst_n = 1'b1;
    run(4, 192, 3, 3456, 1'b0);

    // Rejected configurations leave R=192 and shift=23 in force
    cfg_reject(1);
    cfg_reject(257);
    cfg_reject(6);
    cmp("overrun_after_reject", int'(overrun), 0);
    run(3, 192, 1, 3456, 1'b0);

    // Backpressure: hold the first frame; the second event must overrun
    y_ready = 1'b0;
    push_frame(-1, 1'b1, 3456, 1'b1, 3456);
    x_valid = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 384; i++) begin
      @(posedge clk); #1;
      if (i == 200) begin
        cmp("bp_valid", int'(y_valid), 1);
        cmp("bp_ch", int'(y_ch), 0);
        cmp("bp_value", int'(y_out), 3456);
      end
    end
    cmp("bp_overrun_before", int'(overrun), 0);
    x_valid = 1'b0;
    @(posedge clk); #1;
    cmp("bp_overrun_set", int'(overrun), 1);
    while (cyc < t0 + 494) begin @(posedge clk); #1; end
    y_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    cmp("bp_drained", q.size(), 0);
    cmp("bp_overrun_sticky", int'(overrun), 1);

    // Reconfigure with a simultaneous x_valid: R=64, shift=18 -> 2^38 >> 18 >> 8 = 4096
    do_cfg(64, 18, 1'b1);
    cmp("cfg_clears_overrun", int'(overrun), 0);
    cmp("cfg_clears_valid", int'(y_valid), 0);
    cmp("cfg_accept_no_err", int'(cfg_err), 0);
    run(4, 64, 3, 4096, 1'b0);

    // Saturation with shift=0
    do_cfg(64, 0, 1'b0);
    set_x(1 << 22);
    run(3, 64, 1, 32767, 1'b0);
    do_cfg(64, 0, 1'b0);
    set_x(-(1 << 22));
    run(3, 64, 1, -32768, 1'b0);

    // Channel independence: sine on ch0 only, ch1..3 must be exactly 0
    do_cfg(192, 23, 1'b0);
    set_x(0);
    run(30, 192, 1, 0, 1'b1);

    // Mid-frame reset while a beat is held; R must return to 192
    do_cfg(64, 18, 1'b0);
    set_x(1 << 20);
    y_ready = 1'b0;
    x_valid = 1'b1;
    repeat (100) begin @(posedge clk); #1; end
    cmp("pre_reset_valid", int'(y_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    cmp("mid_rst_y_valid", int'(y_valid), 0);
    cmp("mid_rst_y_out", int'(y_out), 0);
    cmp("mid_rst_y_ch", int'(y_ch), 0);
    cmp("mid_rst_y_last", int'(y_last), 0);
    cmp("mid_rst_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    y_ready = 1'b1;
    run(1, 192, 9, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
